// File: rtl/ysyx_23060236_ifu.sv
// Instruction fetch unit: holds the PC, issues one AXI4-Lite read per instruction
// and hands the fetched word to decode over a valid/ready handshake.
module ysyx_23060236_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [31:0] npc,
  input  logic        npc_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_OUT,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;
  logic        take_pc;

  // Handshake outputs depend on state only, so no input reaches an output.
  assign arvalid    = (state_q == S_REQ);
  assign rready     = (state_q == S_RESP);
  assign inst_valid = (state_q == S_OUT);
  assign araddr     = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

  // The next PC is only consumed when leaving OUT via handshake, or from WAIT.
  assign take_pc = ((state_q == S_OUT) && inst_ready) || (state_q == S_WAIT);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (arready) state_d = S_RESP;
      end
      S_RESP: begin
        if (rvalid) begin
          inst_d       = rdata;
          inst_pc_d    = pc_q;
          inst_fault_d = (rresp != 2'b00);
          state_d      = S_OUT;
        end
      end
      S_OUT: begin
        if (inst_ready) state_d = (npc_valid || pend_v_q) ? S_REQ : S_WAIT;
      end
      S_WAIT: begin
        if (npc_valid || pend_v_q) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh npc beats an older pending one; otherwise park npc until it can be used.
    if (take_pc && npc_valid) begin
      pc_d     = npc;
      pend_v_d = 1'b0;
    end else if (take_pc && pend_v_q) begin
      pc_d     = pend_q;
      pend_v_d = 1'b0;
    end else if (npc_valid && (state_q inside {S_REQ, S_RESP, S_OUT})) begin
      pend_d   = npc;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_ifu.sv
// Scoreboard bench for the IFU: directed fetches push expected AR addresses and
// delivered instructions; a negedge monitor pops and compares on each handshake.
module tb_ysyx_23060236_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] npc;
  logic        npc_valid;

  int n_vec = 0;
  int n_err = 0;
  int ar_cnt = 0;
  int r_cnt = 0;

  logic [31:0] ar_q[$];
  exp_t        exp_q[$];

  ysyx_23060236_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .npc        (npc),
    .npc_valid  (npc_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] data, input logic fault);
    exp_t e;
    e.inst  = data;
    e.pc    = addr;
    e.fault = fault;
    ar_q.push_back(addr);
    exp_q.push_back(e);
  endtask

  // Monitor: compare on handshakes and check holding rules under backpressure.
  logic        prev_arv, prev_ard, prev_iv, prev_ir;
  logic [31:0] prev_addr, prev_inst, prev_pc;
  logic        prev_fault;

  always @(negedge clk) begin
    if (rst) begin
      prev_arv <= 1'b0;
      prev_iv  <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        ar_cnt <= ar_cnt + 1;
        if (ar_q.size() == 0) check("ar_unexpected", 32'(ar_q.size()), 32'd1);
        else check("ar_addr", araddr, ar_q.pop_front());
      end
      if (rvalid && rready) r_cnt <= r_cnt + 1;
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) check("inst_unexpected", 32'(exp_q.size()), 32'd1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("inst", inst, e.inst);
          check("inst_pc", inst_pc, e.pc);
          check("inst_fault", {31'd0, inst_fault}, {31'd0, e.fault});
        end
      end
      if (prev_arv && !prev_ard && arvalid) check("araddr_stable", araddr, prev_addr);
      if (prev_iv && !prev_ir && inst_valid) begin
        check("inst_stable", inst, prev_inst);
        check("inst_pc_stable", inst_pc, prev_pc);
        check("inst_fault_stable", {31'd0, inst_fault}, {31'd0, prev_fault});
      end
      prev_arv   <= arvalid;
      prev_ard   <= arready;
      prev_addr  <= araddr;
      prev_iv    <= inst_valid;
      prev_ir    <= inst_ready;
      prev_inst  <= inst;
      prev_pc    <= inst_pc;
      prev_fault <= inst_fault;
    end
  end

  // Drive one fetch from REQ through the OUT handshake, with per-phase stalls and
  // optional npc pulses in the first REQ and first RESP cycle.
  task automatic run_fetch(input int ar_dly, input int r_dly, input int rdy_dly,
                           input logic [31:0] data, input logic [1:0] resp,
                           input logic p1, input logic [31:0] n1,
                           input logic p2, input logic [31:0] n2);
    check("req_entry", {31'd0, arvalid}, 32'd1);
    for (int i = 0; i <= ar_dly; i++) begin
      arready   = (i == ar_dly);
      npc_valid = p1 && (i == 0);
      npc       = n1;
      step();
    end
    arready   = 1'b0;
    npc_valid = 1'b0;
    check("resp_entry", {31'd0, rready}, 32'd1);
    for (int i = 0; i <= r_dly; i++) begin
      rvalid    = (i == r_dly);
      rdata     = (i == r_dly) ? data : 32'h5a5a_5a5a;
      rresp     = resp;
      npc_valid = p2 && (i == 0);
      npc       = n2;
      step();
    end
    rvalid    = 1'b0;
    rresp     = 2'b00;
    npc_valid = 1'b0;
    check("out_entry", {31'd0, inst_valid}, 32'd1);
    for (int i = 0; i <= rdy_dly; i++) begin
      inst_ready = (i == rdy_dly);
      step();
    end
    inst_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int a0, r0;
    rst = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    inst_ready = 1'b0; npc = '0; npc_valid = 1'b0;
    step();
    step();

    // Reset state
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_araddr", araddr, RESET_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);

    // First fetch at minimum latency; rvalid already high in REQ must be ignored
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hbad0_0bad;
    rst = 1'b0;
    push_exp(RESET_PC, 32'h0000_0413, 1'b0);
    #1 check("idle_after_rst", {31'd0, arvalid}, 32'd0);
    step();
    check("first_araddr", araddr, RESET_PC);
    run_fetch(0, 0, 0, 32'h0000_0413, 2'b00, 1'b0, '0, 1'b0, '0);

    // No npc: park in WAIT
    check("wait_arvalid", {31'd0, arvalid}, 32'd0);
    step();
    check("wait_hold", {31'd0, arvalid | rready | inst_valid}, 32'd0);

    // npc in WAIT -> REQ next cycle
    npc = 32'h8000_0004; npc_valid = 1'b1;
    step();
    npc_valid = 1'b0;
    check("npc_wait_arvalid", {31'd0, arvalid}, 32'd1);
    check("npc_wait_araddr", araddr, 32'h8000_0004);

    // Backpressure in every phase, npc pulsed during RESP
    push_exp(32'h8000_0004, 32'h0010_0093, 1'b0);
    a0 = ar_cnt; r0 = r_cnt;
    run_fetch(3, 4, 5, 32'h0010_0093, 2'b00, 1'b0, '0, 1'b1, 32'h8000_0008);
    check("bp_ar_count", 32'(ar_cnt - a0), 32'd1);
    check("bp_r_count", 32'(r_cnt - r0), 32'd1);
    check("pend_no_wait_arvalid", {31'd0, arvalid}, 32'd1);
    check("pend_no_wait_araddr", araddr, 32'h8000_0008);

    // Collision: pulse in REQ then RESP, newer npc wins
    push_exp(32'h8000_0008, 32'h0020_0113, 1'b0);
    run_fetch(1, 0, 0, 32'h0020_0113, 2'b00, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0020);
    check("collide_arvalid", {31'd0, arvalid}, 32'd1);
    check("collide_araddr", araddr, 32'h8000_0020);

    // Error response still delivered, then OKAY clears the fault flag
    push_exp(32'h8000_0020, 32'hdead_beef, 1'b1);
    run_fetch(1, 1, 1, 32'hdead_beef, 2'b10, 1'b0, '0, 1'b1, 32'h8000_0024);
    check("fault_next_araddr", araddr, 32'h8000_0024);
    push_exp(32'h8000_0024, 32'h0000_0013, 1'b0);
    run_fetch(0, 0, 0, 32'h0000_0013, 2'b00, 1'b0, '0, 1'b0, '0);
    check("after_fault_wait", {31'd0, arvalid}, 32'd0);

    // Async reset while in RESP
    npc = 32'h8000_0030; npc_valid = 1'b1;
    step();
    npc_valid = 1'b0;
    ar_q.push_back(32'h8000_0030);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("pre_rst_rready", {31'd0, rready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rready", {31'd0, rready}, 32'd0);
    check("async_arvalid", {31'd0, arvalid}, 32'd0);
    check("async_araddr", araddr, RESET_PC);
    step();
    step();
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hbad0_0bad;
    rst = 1'b0;
    push_exp(RESET_PC, 32'h0000_0413, 1'b0);
    #1 check("idle_after_rst2", {31'd0, arvalid}, 32'd0);
    step();
    check("restart_araddr", araddr, RESET_PC);
    run_fetch(0, 0, 0, 32'h0000_0413, 2'b00, 1'b0, '0, 1'b0, '0);

    step();
    check("ar_q_drained", 32'(ar_q.size()), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_ifu.md
# ysyx_23060236_ifu

Instruction fetch unit for the multi-cycle NPC core. It holds the architectural PC and issues one instruction read per instruction over a simplified AXI4-Lite read channel (AR/R). It presents the fetched word with its PC to the decode stage over a valid/ready handshake. Decode keys its opcode/funct lookup tables on `inst`. The next fetch starts only after the writeback side supplies the next PC.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `araddr` out 32: read address; always equals the `pc` register.
- `arvalid` out 1: read request valid.
- `arready` in 1: memory accepts the request.
- `rdata` in 32: read data.
- `rresp` in 2: read response; 2'b00 = OKAY, anything else = error.
- `rvalid` in 1: read data valid.
- `rready` out 1: IFU accepts read data.
- `inst` out 32: fetched instruction, registered.
- `inst_pc` out 32: PC of `inst`.
- `inst_fault` out 1: the fetch of `inst` returned a non-OKAY `rresp`.
- `inst_valid` out 1: `inst`, `inst_pc` and `inst_fault` are valid for decode.
- `inst_ready` in 1: decode accepts.
- `npc` in 32: next PC from writeback.
- `npc_valid` in 1: single-cycle pulse; `npc` is valid.

## Operation
- States: IDLE, REQ, RESP, OUT, WAIT. All outputs decode combinationally from the state; the data outputs come from registers.
- IDLE: all handshake outputs are 0. Goes to REQ on the first rising edge after `rst` deasserts.
- REQ: `arvalid`=1. On `arvalid && arready`, go to RESP.
- RESP: `rready`=1. On `rvalid`:
  - capture `inst` <= `rdata`, `inst_pc` <= `pc`, `inst_fault` <= (`rresp` != 0);
  - go to OUT.
- OUT: `inst_valid`=1. On `inst_ready`:
  - if `npc_valid` is high in the same cycle, or a next PC is already pending, load the next PC and go to REQ;
  - otherwise go to WAIT.
- WAIT: on `npc_valid` or a pending next PC, load `pc` and go to REQ.
- Pending-PC register `pend`/`pend_v`:
  - `npc_valid` in REQ, RESP or OUT (when not consumed directly) stores `npc` and sets `pend_v`.
  - Consuming the pending PC clears `pend_v`.
  - When a pending PC and a new `npc_valid` collide, the newer `npc` wins.
- The fetch address is used unchanged: no alignment forcing and no increment inside the IFU. The PC source is solely `npc`.
- An error response does not stop the FSM. The instruction is still delivered, with `inst_fault`=1.

## Timing
- Reset values:
  - state = IDLE; `pc` = `RESET_PC`; `inst` = 0; `inst_pc` = 0; `inst_fault` = 0; `pend_v` = 0.
  - Hence `arvalid` = `rready` = `inst_valid` = 0.
- Reset applies immediately and asynchronously, mid-transaction included: handshake outputs drop the same cycle. Any outstanding memory response is abandoned; memory must also be reset.
- `araddr` is stable while `arvalid`=1. `inst*` outputs are stable while `inst_valid`=1.
- Minimum latency, with `arready`=1 in REQ and `rvalid`=1 in the first RESP cycle:
  - `arvalid` high at cycle N;
  - `rready` at N+1;
  - `inst_valid` at N+2.
- Next-PC latency:
  - `npc_valid` at cycle M while in WAIT gives `arvalid` with `araddr`=`npc` at M+1.
  - `npc_valid` in OUT together with `inst_ready` also gives REQ at M+1.
- No combinational path from any input to any output.
- Exactly one outstanding read at a time; `rvalid` outside RESP is ignored.

## Test plan
- Reset release with `arready`=`rvalid`=1 and `rdata`=32'h0000_0413 -> `araddr`=32'h8000_0000 one cycle after reset; `inst_valid`=1 two cycles later with `inst`=32'h0000_0413, `inst_pc`=32'h8000_0000, `inst_fault`=0.
- Backpressure: `arready` low for 3 cycles, then `rvalid` delayed 4 cycles, then `inst_ready` low for 5 cycles -> `araddr`/`inst` hold stable throughout; exactly one AR and one R handshake occur.
- Next PC: `npc_valid` with `npc`=32'h8000_0004 in WAIT -> next cycle `arvalid`=1, `araddr`=32'h8000_0004. Same pulse during RESP -> after the OUT handshake, REQ to 32'h8000_0004 with no WAIT cycle.
- Pending collision: `npc`=32'h8000_0010 pulsed in REQ, then `npc`=32'h8000_0020 pulsed in RESP -> the next fetch address is 32'h8000_0020.
- Fault: `rresp`=2'b10 with `rdata`=32'hdead_beef -> `inst_valid`=1, `inst_fault`=1, `inst`=32'hdead_beef; the next fetch has `inst_fault`=0 on OKAY.
- Async reset asserted while in RESP -> `rready`=0 immediately; after release, restart from `RESET_PC` via IDLE.
